// File: rtl/c17_bist_pkg.sv
// rtl/c17_bist_pkg.sv - shared types, constants and c17 reference function for the BIST sequencer
// Purpose: FSM state encoding, vector/port widths, MISR polynomial and a
//          combinational c17 model built from the six-NAND netlist.
// Ports:   none (package)
package c17_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_DRAIN,
      ST_COMPARE,
      ST_DONE
   } state_t;

   localparam int         NUM_VEC   = 32;
   localparam int         PI_W      = 5;
   localparam int         PO_W      = 2;
   localparam logic [7:0] MISR_POLY = 8'h1D;   // x^8+x^4+x^3+x^2+1

   // vec bit0=N1, bit1=N2, bit2=N3, bit3=N6, bit4=N7; result bit0=N22, bit1=N23
   function automatic logic [PO_W-1:0] c17_ref(input logic [PI_W-1:0] i_vec);
      logic n10, n11, n16, n19, n22, n23;
      n10 = ~(i_vec[0] & i_vec[2]);
      n11 = ~(i_vec[2] & i_vec[3]);
      n16 = ~(i_vec[1] & n11);
      n19 = ~(n11 & i_vec[4]);
      n22 = ~(n10 & n16);
      n23 = ~(n16 & n19);
      return {n23, n22};
   endfunction

endpackage

// File: rtl/c17_misr.sv
// rtl/c17_misr.sv - multiple-input signature register compacting c17 responses
// Purpose: Galois-style MISR; each enabled step shifts left, folds the
//          polynomial in when the MSB falls out, and XORs the response in.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (loads SEED)
//   i_load         reload SEED (start of a run)
//   i_en           compact i_din this cycle
//   i_din          response word
//   o_sig          current signature
module c17_misr #(
   parameter int               SIG_W = 8,
   parameter int               DIN_W = 2,
   parameter logic [SIG_W-1:0] SEED  = '0,
   parameter logic [SIG_W-1:0] POLY  = 8'h1D
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIN_W-1:0] i_din,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_next;

   always_comb begin
      w_next = {r_sig[SIG_W-2:0], 1'b0}
             ^ (r_sig[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-DIN_W){1'b0}}, i_din};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_sig <= SEED;
      end else if (i_en) begin
         r_sig <= w_next;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/c17_bist_ctrl.sv
// rtl/c17_bist_ctrl.sv - exhaustive BIST sequencer for the clocked c17 core
// Purpose: applies all 32 vectors, captures each response LAT cycles later,
//          compacts the responses in a MISR and compares with GOLDEN.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               begin a run (accepted in IDLE or DONE only)
//   o_pi_vec[4:0]         vector to core (N1,N2,N3,N6,N7 from bit0)
//   i_po_resp[1:0]        core response (N22q, N23q2)
//   o_busy                APPLY through COMPARE
//   o_done                in DONE
//   o_pass                signature matched GOLDEN, valid while done
//   o_signature           MISR contents
//   o_fail_seen,
//   o_fail_idx[4:0]       first-fail diagnosis, present only with C17_BIST_DIAG_EN
// Optional feature macro: C17_BIST_DIAG_EN
module c17_bist_ctrl
   import c17_bist_pkg::*;
#(
   parameter int               LAT    = 2,
   parameter int               SIG_W  = 8,
   parameter logic [SIG_W-1:0] SEED   = '0,
   parameter logic [SIG_W-1:0] GOLDEN = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic [PI_W-1:0]  o_pi_vec,
   input  logic [PO_W-1:0]  i_po_resp,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [SIG_W-1:0] o_signature
`ifdef C17_BIST_DIAG_EN
   ,
   output logic             o_fail_seen,
   output logic [PI_W-1:0]  o_fail_idx
`endif
);

   state_t           r_state, w_next_state;
   logic [PI_W-1:0]  r_cnt;
   logic [LAT-1:0]   r_vp;        // one bit per vector in flight through the core
   logic             r_pass;
   logic             w_apply, w_busy, w_done, w_load;
   logic             w_last_vec, w_drain_end, w_capture, w_sig_ok;
   logic [PI_W-1:0]  w_pi_vec;
   logic [SIG_W-1:0] w_sig;

   // The counter walks vectors in APPLY and is reused to time DRAIN.
   assign w_last_vec  = (r_cnt == PI_W'(NUM_VEC - 1));
   assign w_drain_end = (r_cnt == PI_W'(LAT - 1));
   assign w_capture   = r_vp[LAT-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (i_start)     w_next_state = ST_APPLY;
         ST_APPLY:         if (w_last_vec)  w_next_state = ST_DRAIN;
         ST_DRAIN:         if (w_drain_end) w_next_state = ST_COMPARE;
         ST_COMPARE:                        w_next_state = ST_DONE;
         default:                           w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_apply = (r_state == ST_APPLY);
      w_busy  = (r_state == ST_APPLY) || (r_state == ST_DRAIN) || (r_state == ST_COMPARE);
      w_done  = (r_state == ST_DONE);
      w_load  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_load) begin
         r_cnt <= '0;
      end else if (w_apply) begin
         r_cnt <= w_last_vec ? '0 : r_cnt + 1'b1;
      end else if (r_state == ST_DRAIN) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vp <= '0;
      end else begin
         r_vp[0] <= w_apply;
         for (int i = 1; i < LAT; i++) begin
            r_vp[i] <= r_vp[i-1];
         end
      end
   end

   assign w_pi_vec = w_apply ? r_cnt : '0;

   c17_misr #(
      .SIG_W (SIG_W),
      .DIN_W (PO_W),
      .SEED  (SEED),
      .POLY  (SIG_W'(MISR_POLY))
   ) u_misr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_load),
      .i_en   (w_capture),
      .i_din  (i_po_resp),
      .o_sig  (w_sig)
   );

`ifdef C17_BIST_DIAG_EN
   logic [PO_W-1:0] r_exp [LAT];   // expected responses travelling beside r_vp
   logic [PI_W-1:0] r_cap_idx;
   logic            r_fail_seen;
   logic [PI_W-1:0] r_fail_idx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LAT; i++) begin
            r_exp[i] <= '0;
         end
      end else begin
         r_exp[0] <= c17_ref(w_pi_vec);
         for (int i = 1; i < LAT; i++) begin
            r_exp[i] <= r_exp[i-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_load) begin
         r_cap_idx   <= '0;
         r_fail_seen <= 1'b0;
         r_fail_idx  <= '0;
      end else if (w_capture) begin
         r_cap_idx <= r_cap_idx + 1'b1;
         if (!r_fail_seen && (i_po_resp != r_exp[LAT-1])) begin
            r_fail_seen <= 1'b1;
            r_fail_idx  <= r_cap_idx;
         end
      end
   end

   assign w_sig_ok    = (w_sig == GOLDEN) && !r_fail_seen;
   assign o_fail_seen = r_fail_seen;
   assign o_fail_idx  = r_fail_idx;
`else
   assign w_sig_ok = (w_sig == GOLDEN);
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst || w_load) begin
         r_pass <= 1'b0;
      end else if (r_state == ST_COMPARE) begin
         r_pass <= w_sig_ok;
      end
   end

   assign o_pi_vec    = w_pi_vec;
   assign o_busy      = w_busy;
   assign o_done      = w_done;
   assign o_pass      = r_pass;
   assign o_signature = w_sig;

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
Built-in self-test sequencer for the clocked c17 benchmark core.
- Drives all 32 input vectors to the core exhaustively, one per clock.
- Aligns each response against the core's pipeline latency.
- Compacts the responses into a MISR signature and compares it with a golden value.
- Sits beside the c17 instance, replacing the hand-written vector bench for on-chip and regression test.

Parameters:
LAT, 2, clock cycles from a pi_vec change to the matching po_resp (1..4)
SIG_W, 8, MISR width
SEED, 8'h00, MISR value loaded at reset and at start
GOLDEN, 8'h00, expected final signature (set per build from the reference model)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a test run; sampled in IDLE or DONE only
pi_vec  out  5  vector to core; bit0=N1, bit1=N2, bit2=N3, bit3=N6, bit4=N7
po_resp  in  2  core outputs; bit0=N22q, bit1=N23q2
busy  out  1  high from the first APPLY cycle through COMPARE
done  out  1  high in DONE, held until next start or rst
pass  out  1  signature==GOLDEN, valid while done
signature  out  SIG_W  MISR contents, final value stable in DONE

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-run): state=IDLE, pi_vec=0, busy=0, done=0, pass=0, signature=SEED, vector counter=0, latency valid-pipe cleared.
- FSM states: IDLE, APPLY, DRAIN, COMPARE, DONE.
- IDLE/DONE with start=1 at edge t:
  - Go to APPLY and reload MISR=SEED.
  - Clear done and pass; set counter=0.
- start is ignored in APPLY, DRAIN and COMPARE.
- APPLY: 32 cycles, t+1..t+32.
  - pi_vec=counter (0..31); the counter increments each cycle.
  - After counter=31, go to DRAIN; there is no wrap into a 33rd vector.
  - Each applied vector pushes a 1 into a LAT-deep valid shift register.
- Capture: when the valid bit exits the shift register, po_resp is sampled.
  - Vector k is sampled at cycle t+1+k+LAT.
  - Exactly 32 samples are taken per run.
- MISR step: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? 8'h1D : 0) ^ {6'b0,po_resp}. The polynomial is x^8+x^4+x^3+x^2+1.
- DRAIN: LAT cycles, t+33..t+32+LAT. pi_vec holds 0 and the last responses are captured.
- COMPARE: 1 cycle, at t+33+LAT. The registered compare signature==GOLDEN is loaded into pass.
- DONE: entered at t+34+LAT.
  - done=1, busy=0, pi_vec=0.
  - pass and signature are held.
- Simultaneous rst and start: rst wins.

Optional Feature:
Macro C17_BIST_DIAG_EN adds first-fail diagnosis.
- Ports added: fail_seen (out, 1) and fail_idx (out, 5). Both reset to 0 and clear on start.
- An internal combinational c17 model computes the expected response from pi_vec. It is delayed LAT cycles in step with the valid pipe.
- On the first captured mismatch, fail_seen=1 and fail_idx=k are set and latched until the next start or rst.
- pass additionally requires fail_seen=0.
- Without the macro: the ports and model are absent, and pass depends on the signature only.

Decomposition:
- Package c17_bist_pkg:
  - state enum (IDLE..DONE)
  - NUM_VEC=32
  - MISR_POLY=8'h1D
  - PI_W=5, PO_W=2
  - function c17_ref(5-bit)->2-bit, defined by the NAND netlist: N10=~(N1&N3), N11=~(N3&N6), N16=~(N2&N11), N19=~(N11&N7), N22=~(N10&N16), N23=~(N16&N19)
- One natural sub-module: c17_misr (clk, rst, load, en, din[1:0], sig).

Test Plan:
1. rst held 3 cycles, then released, start never asserted -> busy=0, done=0, pass=0, pi_vec=0, signature=8'h00 every cycle.
2. po_resp tied 2'b00, GOLDEN=8'h00, start pulse at edge t -> pi_vec steps 0..31 on t+1..t+32, busy rises at t+1, done rises at t+36, signature=8'h00, pass=1.
3. Real c17 (LAT=2) attached, GOLDEN set from c17_ref plus MISR model -> pass=1 and signature equals the model value. With N22q forced stuck-at-1 -> pass=0; with DIAG_EN, fail_seen=1 and fail_idx=0 (expected response 2'b00 for vector 0).
4. rst asserted at t+10 mid-APPLY -> next cycle state IDLE, pi_vec=0, busy=0, signature=SEED. A following start gives a full, correct 32-vector run.
5. start re-pulsed at t+5 during APPLY -> ignored, done still at t+36. start in DONE -> done clears the next cycle and the run repeats with the identical signature.
6. LAT=4 build -> first capture at t+5, done at t+38, and the same signature as the LAT=2 run for an identical core.
